// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared definitions for the forwarding / hazard unit.
//   - forwarding stage indices (youngest stage has the lowest index and wins)
//   - encoding of "no forwarding, read the register file"
//   - outstanding-counter update operation
// Optional feature macro used by the top: FWD_SB_STATS_EN.
package fwd_scoreboard_pkg;

   // Forwarding stage indices; index 0 is the youngest and has highest priority.
   localparam int unsigned FWD_STG_EX  = 0;
   localparam int unsigned FWD_STG_MEM = 1;
   localparam int unsigned FWD_STG_WB  = 2;

   // All-zero select means the operand comes from the register file.
   localparam int unsigned FWD_NONE = 0;

   // Outstanding long-latency counter update.
   typedef enum logic [1:0] {
      CntHold,
      CntInc,
      CntDec
   } cnt_op_e;

endpackage

// File: rtl/fwd_prio_sel.sv
// fwd_prio_sel: per-source priority selector.
// Turns the stage match vector into a one-hot select on the lowest matching stage
// (youngest producer) and reports whether that producer is not yet ready.
// Ports:
//   match_i  stage s holds a valid write to this source register
//   ready_i  stage s result is available for forwarding this cycle
//   sel_o    one-hot stage select, all-zero when nothing matches
//   hit_o    some stage matched
//   wait_o   winning stage exists but its result is not ready
module fwd_prio_sel #(
   parameter int unsigned NUM_STAGES = 3
) (
   input  logic [NUM_STAGES-1:0] match_i,
   input  logic [NUM_STAGES-1:0] ready_i,
   output logic [NUM_STAGES-1:0] sel_o,
   output logic                  hit_o,
   output logic                  wait_o
);

   // Isolate the lowest set bit: x & -x.
   assign sel_o  = match_i & (~match_i + NUM_STAGES'(1));
   assign hit_o  = |match_i;
   assign wait_o = |(sel_o & ~ready_i);

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and hazard unit for one register file (INT or FP), sits in ID.
// Picks the youngest in-flight producer per source operand, keeps a busy bit per register
// for long-latency ops, and raises stall for unready producers, busy sources, WAW against
// a long op, and issue while the scoreboard is full.
// Optional feature: define FWD_SB_STATS_EN to add stat_stall_cnt / stat_fwd_cnt outputs.
// Ports:
//   clk, reset_n                clock, async active-low reset
//   src_rs, src_used            ID source registers (packed) and their use flags
//   id_rd, id_wr                ID destination for the WAW check
//   stage_rd/_wr/_ready         per-stage destination, write-valid, result-ready
//   issue_valid/_rd/_kill       long-latency op entering its unit
//   cmpl_valid, cmpl_rd         long-latency result entering a forwarding stage
//   fwd_sel                     one-hot stage select per source (0 = regfile)
//   stall                       hold ID (combinational)
//   sb_full                     outstanding long ops == MAX_LONG (registered)
//   busy_vec                    registered per-register busy scoreboard
//   err_spurious                1-cycle pulse: completion to a non-busy register
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_SRC      = 3,
   parameter int unsigned NUM_STAGES   = 3,
   parameter int unsigned MAX_LONG     = 4,
   parameter bit          HAS_ZERO_REG = 1'b1,
   localparam int unsigned REG_W       = $clog2(NUM_REGS),
   localparam int unsigned CNT_W       = $clog2(MAX_LONG + 1)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_SRC*REG_W-1:0]      src_rs,
   input  logic [NUM_SRC-1:0]            src_used,
   input  logic [REG_W-1:0]              id_rd,
   input  logic                          id_wr,
   input  logic [NUM_STAGES*REG_W-1:0]   stage_rd,
   input  logic [NUM_STAGES-1:0]         stage_wr,
   input  logic [NUM_STAGES-1:0]         stage_ready,
   input  logic                          issue_valid,
   input  logic [REG_W-1:0]              issue_rd,
   input  logic                          issue_kill,
   input  logic                          cmpl_valid,
   input  logic [REG_W-1:0]              cmpl_rd,
   output logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel,
   output logic                          stall,
   output logic                          sb_full,
   output logic [NUM_REGS-1:0]           busy_vec,
   output logic                          err_spurious
`ifdef FWD_SB_STATS_EN
   ,
   output logic [31:0]                   stat_stall_cnt,
   output logic [31:0]                   stat_fwd_cnt
`endif
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sb_full_q, sb_full_d;
   logic                err_q, err_d;

   logic [NUM_SRC-1:0]  src_hit;
   logic [NUM_SRC-1:0]  src_wait;
   logic [NUM_SRC-1:0]  src_busy;

   // ---------------------------------------------------------------------------
   // Per-source forwarding match and selection
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_W-1:0]      rs;
      logic                  zero_src;
      logic [NUM_STAGES-1:0] match;

      assign rs       = src_rs[i*REG_W +: REG_W];
      assign zero_src = HAS_ZERO_REG && (rs == '0);

      for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stg
         assign match[s] = src_used[i] & stage_wr[s] &
                           (stage_rd[s*REG_W +: REG_W] == rs) & ~zero_src;
      end

      fwd_prio_sel #(
         .NUM_STAGES (NUM_STAGES)
      ) u_prio_sel (
         .match_i (match),
         .ready_i (stage_ready),
         .sel_o   (fwd_sel[i*NUM_STAGES +: NUM_STAGES]),
         .hit_o   (src_hit[i]),
         .wait_o  (src_wait[i])
      );

      // Only consult the scoreboard when no in-flight stage supplies the value.
      assign src_busy[i] = src_used[i] & ~src_hit[i] & busy_q[rs];
   end

   // ---------------------------------------------------------------------------
   // Stall OR-tree
   // ---------------------------------------------------------------------------
   logic waw_stall;
   logic full_stall;

   assign waw_stall  = id_wr & busy_q[id_rd];
   assign full_stall = sb_full_q & issue_valid;
   assign stall      = (|src_wait) | (|src_busy) | waw_stall | full_stall;

   // ---------------------------------------------------------------------------
   // Scoreboard and outstanding counter next state
   // ---------------------------------------------------------------------------
   logic    set_req, set_ok, clear, cnt_full;
   cnt_op_e cnt_op;

   always_comb begin
      set_req  = issue_valid & ~issue_kill & ~(HAS_ZERO_REG && (issue_rd == '0));
      clear    = cmpl_valid & busy_q[cmpl_rd];
      cnt_full = (cnt_q == CNT_W'(MAX_LONG));
      // Issue while full is dropped unless a completion frees a slot the same cycle.
      set_ok   = set_req & (~cnt_full | clear);

      busy_d = busy_q;
      if (clear) begin
         busy_d[cmpl_rd] = 1'b0;
      end
      // Set after clear so a same-register set/clear leaves the bit busy.
      if (set_ok) begin
         busy_d[issue_rd] = 1'b1;
      end

      cnt_op = CntHold;
      if (set_ok && !clear) begin
         cnt_op = CntInc;
      end else if (clear && !set_ok) begin
         cnt_op = CntDec;
      end

      cnt_d = cnt_q;
      unique case (cnt_op)
         CntInc:  cnt_d = cnt_q + CNT_W'(1);
         CntDec:  cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      sb_full_d = (cnt_d == CNT_W'(MAX_LONG));
      err_d     = cmpl_valid & ~busy_q[cmpl_rd];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q    <= '0;
         cnt_q     <= '0;
         sb_full_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         sb_full_q <= sb_full_d;
         err_q     <= err_d;
      end
   end

   assign busy_vec     = busy_q;
   assign sb_full      = sb_full_q;
   assign err_spurious = err_q;

`ifdef FWD_SB_STATS_EN
   // ---------------------------------------------------------------------------
   // Activity counters, free-running and wrapping
   // ---------------------------------------------------------------------------
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (|fwd_sel) begin
         fwd_cnt_d = fwd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stat_stall_cnt = stall_cnt_q;
   assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
